// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC receive/transmit CRC datapath.
package mac_pkg;

  // Mirror a 32-bit word end for end; used to derive the LSB-first polynomial.
  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  // The CRC is computed LSB-first, so the shift register uses the mirrored polynomial.
  localparam logic [31:0] CRC_POLY_REFL = bit_reverse32(CRC_POLY);
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  // Remainder left in the register after folding a frame plus its own FCS.
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  // The FCS is 4 bytes long, so this is also the depth of the byte delay line.
  localparam int DLY_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PASS = 2'd2
  } rx_state_t;

  // Everything the receive checker presents downstream, registered as one bundle.
  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       sop;
    logic       eop;
    logic       fcs_ok;
    logic       len_err;
    logic       abort;
    logic       good;
    logic       crc_err;
    logic       runt;
  } rx_out_t;

endpackage

// File: rtl/mac_crc32_next.sv
// Combinational CRC-32 step: fold one byte, LSB first, into the running register.
module mac_crc32_next
  import mac_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Eight serial shift steps unrolled into one combinational stage.
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/mac_rx_fcs_check.sv
// Receive FCS checker: strips the 4-byte FCS, validates CRC and frame length,
// and reports aborts, runts and per-frame statistics. Never back-pressures.
module mac_rx_fcs_check
  import mac_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  input  logic       s_sop_i,
  input  logic       s_eop_i,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  output logic       m_sop_o,
  output logic       m_eop_o,
  output logic       m_fcs_ok_o,
  output logic       m_len_err_o,
  output logic       m_abort_o,
  output logic       stat_good_o,
  output logic       stat_crc_err_o,
  output logic       stat_runt_o
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  rx_state_t   state_reg, state_next;
  logic [31:0] crc_reg, crc_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  occ_reg, occ_next;
  logic        first_reg, first_next;
  logic [7:0]  dly_reg   [DLY_DEPTH];
  logic [7:0]  dly_next  [DLY_DEPTH];
  logic [7:0]  dly_shift [DLY_DEPTH];
  rx_out_t     out_reg, out_next;

  logic [31:0] crc_seed;
  logic [31:0] crc_calc;
  logic [15:0] cnt_inc;
  logic        shift_en;
  logic        fcs_ok;
  logic        len_err;

  // A start-of-frame byte always restarts the CRC from the init value.
  assign crc_seed = s_sop_i ? CRC_INIT : crc_reg;

  mac_crc32_next u_crc (
    .crc_in (crc_seed),
    .data   (s_data_i),
    .crc_out(crc_calc)
  );

  // Byte count including the current byte, pinned at the top of the range.
  assign cnt_inc = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
  assign fcs_ok  = (crc_calc == CRC_RESIDUE);
  assign len_err = (cnt_inc < MIN_L) || (cnt_inc > MAX_L);

  // Shifted view of the delay line: new byte at entry 0, oldest falls out of the last entry.
  for (genvar gi = 0; gi < DLY_DEPTH; gi++) begin : g_dly
    if (gi == 0) begin : g_head
      assign dly_shift[gi] = s_data_i;
    end else begin : g_tail
      assign dly_shift[gi] = dly_reg[gi-1];
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, datapath updates and the output bundle for the next cycle.
  always_comb begin
    state_next = state_reg;
    crc_next   = crc_reg;
    cnt_next   = cnt_reg;
    occ_next   = occ_reg;
    first_next = first_reg;
    shift_en   = 1'b0;
    out_next   = '0;

    if (s_valid_i) begin
      if (s_sop_i) begin
        // A new frame pre-empts whatever was in flight; only a frame that
        // already delivered bytes needs an abort downstream.
        out_next.abort = (state_reg == ST_PASS);
        if (s_eop_i) begin
          out_next.runt = 1'b1;
          state_next    = ST_IDLE;
          occ_next      = 3'd0;
          cnt_next      = 16'd0;
          crc_next      = CRC_INIT;
        end else begin
          state_next = ST_FILL;
          occ_next   = 3'd1;
          cnt_next   = 16'd1;
          crc_next   = crc_calc;
          first_next = 1'b1;
          shift_en   = 1'b1;
        end
      end else begin
        unique case (state_reg)
          ST_FILL: begin
            crc_next = crc_calc;
            cnt_next = cnt_inc;
            shift_en = 1'b1;
            if (s_eop_i) begin
              out_next.runt = 1'b1;
              state_next    = ST_IDLE;
              occ_next      = 3'd0;
            end else begin
              occ_next = occ_reg + 3'd1;
              if (occ_reg == 3'(DLY_DEPTH - 1)) begin
                state_next = ST_PASS;
              end
            end
          end
          ST_PASS: begin
            crc_next       = crc_calc;
            cnt_next       = cnt_inc;
            shift_en       = 1'b1;
            first_next     = 1'b0;
            out_next.data  = dly_reg[DLY_DEPTH-1];
            out_next.valid = 1'b1;
            out_next.sop   = first_reg;
            if (s_eop_i) begin
              // The delay line now holds exactly the FCS bytes, which are dropped.
              out_next.eop     = 1'b1;
              out_next.fcs_ok  = fcs_ok;
              out_next.len_err = len_err;
              out_next.good    = fcs_ok && !len_err;
              out_next.crc_err = !(fcs_ok && !len_err);
              state_next       = ST_IDLE;
              occ_next         = 3'd0;
            end
          end
          default: begin
            // Stray bytes between frames are ignored.
          end
        endcase
      end
    end

    if (shift_en) begin
      dly_next = dly_shift;
    end else begin
      dly_next = dly_reg;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      crc_reg   <= CRC_INIT;
      cnt_reg   <= 16'd0;
      occ_reg   <= 3'd0;
      first_reg <= 1'b0;
      out_reg   <= '0;
      for (int i = 0; i < DLY_DEPTH; i++) begin
        dly_reg[i] <= 8'd0;
      end
    end else begin
      crc_reg   <= crc_next;
      cnt_reg   <= cnt_next;
      occ_reg   <= occ_next;
      first_reg <= first_next;
      out_reg   <= out_next;
      for (int i = 0; i < DLY_DEPTH; i++) begin
        dly_reg[i] <= dly_next[i];
      end
    end
  end

  assign m_data_o       = out_reg.data;
  assign m_valid_o      = out_reg.valid;
  assign m_sop_o        = out_reg.sop;
  assign m_eop_o        = out_reg.eop;
  assign m_fcs_ok_o     = out_reg.fcs_ok;
  assign m_len_err_o    = out_reg.len_err;
  assign m_abort_o      = out_reg.abort;
  assign stat_good_o    = out_reg.good;
  assign stat_crc_err_o = out_reg.crc_err;
  assign stat_runt_o    = out_reg.runt;

endmodule

// File: tb/tb_mac_rx_fcs_check.sv
// Scoreboard bench for mac_rx_fcs_check: expected events are queued as frames
// are driven and compared as the checker emits bytes, aborts and runt pulses.
module tb_mac_rx_fcs_check;

  localparam int TB_MIN = 9;
  localparam int TB_MAX = 1518;
  localparam int K_BYTE  = 0;
  localparam int K_ABORT = 1;
  localparam int K_RUNT  = 2;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       ok;
    logic       lenerr;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] s_data_i = 8'd0;
  logic       s_valid_i = 1'b0;
  logic       s_sop_i = 1'b0;
  logic       s_eop_i = 1'b0;
  logic [7:0] m_data_o;
  logic       m_valid_o, m_sop_o, m_eop_o, m_fcs_ok_o, m_len_err_o, m_abort_o;
  logic       stat_good_o, stat_crc_err_o, stat_runt_o;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_kind;

  mac_rx_fcs_check #(.MIN_LEN(TB_MIN), .MAX_LEN(TB_MAX)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .s_data_i      (s_data_i),
    .s_valid_i     (s_valid_i),
    .s_sop_i       (s_sop_i),
    .s_eop_i       (s_eop_i),
    .m_data_o      (m_data_o),
    .m_valid_o     (m_valid_o),
    .m_sop_o       (m_sop_o),
    .m_eop_o       (m_eop_o),
    .m_fcs_ok_o    (m_fcs_ok_o),
    .m_len_err_o   (m_len_err_o),
    .m_abort_o     (m_abort_o),
    .stat_good_o   (stat_good_o),
    .stat_crc_err_o(stat_crc_err_o),
    .stat_runt_o   (stat_runt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference CRC over a byte list (standard reflected byte-at-a-time form).
  function automatic logic [31:0] ref_crc(input byte_q_t q);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      c ^= {24'd0, q[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return c;
  endfunction

  // Random payload followed by its FCS; optionally flip bit 0 of one byte afterwards.
  function automatic byte_q_t make_frame(input int payload_len, input int corrupt_idx);
    byte_q_t     q;
    logic [31:0] fcs;
    for (int i = 0; i < payload_len; i++) q.push_back(8'($urandom));
    fcs = ~ref_crc(q);
    for (int i = 0; i < 4; i++) q.push_back(fcs[8*i +: 8]);
    if (corrupt_idx >= 0) q[corrupt_idx] = q[corrupt_idx] ^ 8'h01;
    return q;
  endfunction

  task automatic push_event(input int kind);
    exp_t e;
    e.kind = kind; e.data = 8'd0; e.sop = 1'b0; e.eop = 1'b0; e.ok = 1'b0; e.lenerr = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle();
    s_valid_i = 1'b0; s_sop_i = 1'b0; s_eop_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  // Drive the first n_drive bytes of fr; gap_mode 0 = back-to-back, 1 = valid toggles, 2 = random gaps.
  task automatic send_frame(input string name, input byte_q_t fr, input int n_drive,
                            input int gap_mode, input bit ok_exp);
    int  n = fr.size();
    bit  complete = (n_drive == n);
    int  n_out = (n_drive > 4) ? (complete ? n - 4 : n_drive - 4) : 0;
    exp_t e;
    if (complete && n <= 4) push_event(K_RUNT);
    for (int j = 0; j < n_out; j++) begin
      e.kind = K_BYTE; e.data = fr[j]; e.sop = (j == 0);
      e.eop = complete && (j == n_out - 1);
      e.ok = ok_exp; e.lenerr = (n < TB_MIN) || (n > TB_MAX);
      exp_q.push_back(e);
    end
    $display("tx %s: %0d of %0d bytes, gap_mode %0d, expect %0d out", name, n_drive, n, gap_mode, n_out);
    for (int i = 0; i < n_drive; i++) begin
      if (gap_mode == 1 && i > 0) idle_cycle();
      if (gap_mode == 2) repeat ($urandom_range(0, 2)) idle_cycle();
      s_data_i = fr[i]; s_valid_i = 1'b1; s_sop_i = (i == 0); s_eop_i = (i == n - 1);
      @(posedge clk_i); #1;
    end
    s_valid_i = 1'b0; s_sop_i = 1'b0; s_eop_i = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val(tag, {m_data_o, m_valid_o, m_sop_o, m_eop_o, m_fcs_ok_o, m_len_err_o, m_abort_o,
                    stat_good_o, stat_crc_err_o, stat_runt_o}, 32'd0);
  endtask

  // Output monitor: every output event must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (m_valid_o || m_abort_o || stat_runt_o || stat_good_o || stat_crc_err_o) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_event", {m_valid_o, m_abort_o, stat_runt_o, stat_good_o, stat_crc_err_o}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_kind = m_valid_o ? K_BYTE : (m_abort_o ? K_ABORT : K_RUNT);
        check_val("event_kind", mon_kind, mon_e.kind);
        if (mon_e.kind == K_BYTE) begin
          check_val("data", m_data_o, mon_e.data);
          check_val("sop", m_sop_o, mon_e.sop);
          check_val("eop", m_eop_o, mon_e.eop);
          if (mon_e.eop) begin
            check_val("fcs_ok", m_fcs_ok_o, mon_e.ok);
            check_val("len_err", m_len_err_o, mon_e.lenerr);
            check_val("stat_good", stat_good_o, mon_e.ok && !mon_e.lenerr);
            check_val("stat_crc_err", stat_crc_err_o, !(mon_e.ok && !mon_e.lenerr));
          end else begin
            check_val("stat_mid", {stat_good_o, stat_crc_err_o}, 32'd0);
          end
        end else if (mon_e.kind == K_ABORT) begin
          check_val("abort_valid", m_valid_o, 32'd0);
        end else begin
          check_val("runt_valid", m_valid_o, 32'd0);
        end
      end
    end
  end

  initial begin
    #(10 * 50000);
    $display("FAIL timeout: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    byte_q_t fr, fr_b, vec;
    vec = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};

    repeat (3) @(posedge clk_i);
    #1 check_outputs_zero("reset_outputs");
    reset_i = 1'b0;
    @(posedge clk_i); #1;

    // Stray bytes without sop must be ignored.
    for (int i = 0; i < 5; i++) begin
      s_data_i = 8'(i + 8'h50); s_valid_i = 1'b1;
      @(posedge clk_i); #1;
    end
    idle_cycle();

    send_frame("check_vector", vec, vec.size(), 0, 1'b1);
    fr = vec; fr[4] = fr[4] ^ 8'h01;
    send_frame("check_vector_bad", fr, fr.size(), 0, 1'b0);
    send_frame("frame64_toggle", make_frame(60, -1), 64, 1, 1'b1);

    fr = '{8'hAA, 8'hBB, 8'hCC};
    send_frame("runt3", fr, 3, 0, 1'b0);
    fr = '{8'h5A};
    send_frame("runt1", fr, 1, 0, 1'b0);
    send_frame("runt4", make_frame(0, -1), 4, 0, 1'b1);
    send_frame("frame5", make_frame(1, -1), 5, 2, 1'b1);
    send_frame("frame8_short", make_frame(4, -1), 8, 0, 1'b1);
    send_frame("frame9_min", make_frame(5, -1), 9, 0, 1'b1);

    // sop in PASS: frame A cut after 10 bytes, abort, then B.
    fr = make_frame(60, -1);
    send_frame("frame_a_cut", fr, 10, 0, 1'b1);
    push_event(K_ABORT);
    send_frame("frame_b", make_frame(60, -1), 64, 0, 1'b1);

    // sop in FILL: frame A cut after 3 bytes is dropped silently.
    send_frame("frame_a_fill", fr, 3, 0, 1'b1);
    send_frame("frame_b_gaps", make_frame(60, -1), 64, 2, 1'b1);

    // Reset at byte 20 of a 64-byte frame.
    send_frame("frame_reset", make_frame(60, -1), 19, 0, 1'b1);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    check_outputs_zero("mid_reset_outputs");
    reset_i = 1'b0;
    idle_cycle();
    check_outputs_zero("post_reset_outputs");
    fr_b = make_frame(60, 20);
    send_frame("after_reset_bad", fr_b, 64, 0, 1'b0);
    send_frame("after_reset_good", make_frame(60, -1), 64, 0, 1'b1);

    send_frame("frame1518_max", make_frame(1514, -1), 1518, 0, 1'b1);
    send_frame("frame1519_long", make_frame(1515, -1), 1519, 0, 1'b1);

    repeat (10) idle_cycle();
    check_val("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
